// File: rtl/frogger_pkg.sv
// frogger_pkg: shared Frogger grid constants, FSM state and direction encodings (also used by the renderer)
package frogger_pkg;
  localparam int COLS = 20;
  localparam int ROWS = 10;
  localparam int CELL_W = 32;
  localparam int CELL_H = 48;
  localparam int START_COL = 9;
  localparam logic [4:0] COL_MAX = 5'(COLS - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
  localparam logic [4:0] COL_START = 5'(START_COL);
  typedef enum logic [1:0] {PLAY, HIT, WIN, OVER} state_e;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
endpackage

// File: rtl/frog_move_ctrl_if.sv
// frog_move_ctrl_if: player-control bundle. Raw buttons and enemy cell in; frog cell, lives, status flags and move strobe out.
// master = game/board side driving buttons and enemy position, slave = frog_move_ctrl.
interface frog_move_ctrl_if;
  logic btn_up;
  logic btn_down;
  logic btn_left;
  logic btn_right;
  logic [4:0] enemy_col;
  logic [3:0] enemy_row;
  logic [4:0] frog_col;
  logic [3:0] frog_row;
  logic [1:0] lives;
  logic hit;
  logic won;
  logic game_over;
  logic move_pulse;
  modport master(
    output btn_up, btn_down, btn_left, btn_right, enemy_col, enemy_row,
    input frog_col, frog_row, lives, hit, won, game_over, move_pulse
  );
  modport slave(
    input btn_up, btn_down, btn_left, btn_right, enemy_col, enemy_row,
    output frog_col, frog_row, lives, hit, won, game_over, move_pulse
  );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, stability counter and rising-press pulse for one raw button.
// Ports: clock, rev_reset (async, active-low), btn (raw, async), pulse (one cycle per debounced press).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic rev_reset,
  input  logic btn,
  output logic pulse
);
  localparam int W = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic lvl;
  logic acc;
  logic [W-1:0] cnt;
  logic done;
  assign done = cnt == LAST;
  // pulse is decoded from registers only, so the consumer can register it on the next edge
  assign pulse = done && lvl && !acc;
  always_ff @(posedge clock or negedge rev_reset)
    if (!rev_reset) begin
      sync <= '0;
      lvl <= 1'b0;
      acc <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      lvl <= sync[1];
      cnt <= sync[1] != lvl ? '0 : done ? cnt : cnt + 1'b1;
      if (done) acc <= lvl;
    end
endmodule

// File: rtl/frog_move_ctrl.sv
// frog_move_ctrl: debounced frog movement on the grid, enemy collision, lives and win/game-over FSM.
// Ports: clock, rev_reset (async, active-low), bus (frog_move_ctrl_if.slave: buttons, enemy cell in; frog cell, lives, hit, won, game_over, move_pulse out).
// Build option: define FROG_WRAP_EN to make horizontal moves wrap around instead of clamping.
module frog_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HIT_CYCLES = 25000000
) (
  input logic clock,
  input logic rev_reset,
  frog_move_ctrl_if.slave bus
);
  import frogger_pkg::*;
  localparam logic [24:0] HIT_LAST = 25'(HIT_CYCLES - 1);
  logic [3:0] raw, p;
  state_e state, state_n;
  dir_e dir;
  logic [4:0] col, col_n;
  logic [3:0] row, row_n;
  logic [1:0] lives, lives_n;
  logic [24:0] hit_cnt, hc_n;
  logic mp, mp_n;
  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock(clock), .rev_reset(rev_reset), .btn(raw[i]), .pulse(p[i])
    );
  end
  always_comb begin
    dir = p[0] ? DIR_UP : p[1] ? DIR_DOWN : p[2] ? DIR_LEFT : DIR_RIGHT;
    state_n = state;
    col_n = col;
    row_n = row;
    lives_n = lives;
    hc_n = hit_cnt;
    mp_n = 1'b0;
    case (state)
      PLAY:
        if (row == bus.enemy_row && col == bus.enemy_col) begin
          state_n = HIT;
          lives_n = lives - 2'd1;
          hc_n = '0;
        end else if (row == ROW_MAX) state_n = WIN;
        else if (|p)
          case (dir)
            DIR_UP: begin row_n = row == ROW_MAX ? row : row + 4'd1; mp_n = row != ROW_MAX; end
            DIR_DOWN: begin row_n = row == '0 ? row : row - 4'd1; mp_n = row != '0; end
`ifdef FROG_WRAP_EN
            DIR_LEFT: begin col_n = col == '0 ? COL_MAX : col - 5'd1; mp_n = 1'b1; end
            DIR_RIGHT: begin col_n = col == COL_MAX ? '0 : col + 5'd1; mp_n = 1'b1; end
`else
            DIR_LEFT: begin col_n = col == '0 ? col : col - 5'd1; mp_n = col != '0; end
            DIR_RIGHT: begin col_n = col == COL_MAX ? col : col + 5'd1; mp_n = col != COL_MAX; end
`endif
          endcase
      HIT:
        if (hit_cnt == HIT_LAST) begin
          state_n = lives == '0 ? OVER : PLAY;
          row_n = lives == '0 ? row : '0;
          col_n = lives == '0 ? col : COL_START;
        end else hc_n = hit_cnt + 25'd1;
      WIN, OVER:
        if (|p) begin
          state_n = PLAY;
          row_n = '0;
          col_n = COL_START;
          lives_n = 2'd3;
        end
    endcase
  end
  always_ff @(posedge clock or negedge rev_reset)
    if (!rev_reset) begin
      state <= PLAY;
      col <= COL_START;
      row <= '0;
      lives <= 2'd3;
      hit_cnt <= '0;
      mp <= 1'b0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      lives <= lives_n;
      hit_cnt <= hc_n;
      mp <= mp_n;
    end
  assign bus.frog_col = col;
  assign bus.frog_row = row;
  assign bus.lives = lives;
  assign bus.move_pulse = mp;
  assign bus.hit = state == HIT;
  assign bus.won = state == WIN;
  assign bus.game_over = state == OVER;
endmodule

// File: tb/tb_frog_move_ctrl.sv
// tb_frog_move_ctrl: directed self-checking bench for frog_move_ctrl with a move scoreboard.
module tb_frog_move_ctrl;
  logic clock = 1'b0;
  logic rev_reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int p0, start, n, h;
  logic [8:0] exp_q[$];

  frog_move_ctrl_if bus();
  frog_move_ctrl #(.DEBOUNCE_CYCLES(4), .HIT_CYCLES(8)) dut (
    .clock(clock), .rev_reset(rev_reset), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance n cycles, sampling at the falling edge; every move strobe pops the scoreboard
  task automatic tick(input int cnt = 1);
    logic [8:0] e;
    repeat (cnt) begin
      @(negedge clock);
      cyc++;
      if (bus.move_pulse === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
        chk("pulse_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("move_pos", {bus.frog_row, bus.frog_col}, e);
        end
      end
    end
  endtask

  task automatic btn(input int b, input logic v);
    case (b)
      0: bus.btn_up = v;
      1: bus.btn_down = v;
      2: bus.btn_left = v;
      default: bus.btn_right = v;
    endcase
  endtask

  task automatic press(input int b);
    btn(b, 1'b1);
    tick(8);
    btn(b, 1'b0);
    tick(8);
  endtask

  task automatic do_reset();
    rev_reset = 1'b0;
    tick(2);
    rev_reset = 1'b1;
    tick(1);
  endtask

  task automatic hit_round(input logic [1:0] exp_lives);
    exp_q.push_back({4'd1, 5'd9});
    btn(0, 1'b1);
    n = 0;
    while (bus.move_pulse !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("hit_move_seen", 32'(n < 20), 1);
    tick(1);
    chk("hit_entry", bus.hit, 1);
    chk("hit_lives", bus.lives, exp_lives);
    h = 1;
    while (bus.hit === 1'b1 && h < 20) begin
      tick(1);
      if (bus.hit === 1'b1) h++;
    end
    chk("hit_len", h, 8);
    btn(0, 1'b0);
    chk("after_hit_over", bus.game_over, exp_lives == 2'd0);
    chk("after_hit_row", bus.frog_row, exp_lives == 2'd0 ? 1 : 0);
    chk("after_hit_col", bus.frog_col, 9);
    tick(8);
  endtask

  initial begin
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.enemy_row = 4'd9;
    bus.enemy_col = 5'd19;
    do_reset();
    chk("rst_row", bus.frog_row, 0);
    chk("rst_col", bus.frog_col, 9);
    chk("rst_lives", bus.lives, 3);
    chk("rst_flags", {bus.hit, bus.won, bus.game_over, bus.move_pulse}, 0);

    // single held press: one strobe, 7 cycles after the raw edge
    p0 = pulses;
    exp_q.push_back({4'd1, 5'd9});
    start = cyc;
    btn(0, 1'b1);
    tick(20);
    chk("up_latency", pulse_cyc - start, 7);
    chk("up_pulses", pulses - p0, 1);
    btn(0, 1'b0);
    tick(8);
    chk("up_row", bus.frog_row, 1);

    // glitch rejected, bounce then hold gives one move
    p0 = pulses;
    btn(3, 1'b1);
    tick(2);
    btn(3, 1'b0);
    tick(10);
    chk("glitch_pulses", pulses - p0, 0);
    chk("glitch_col", bus.frog_col, 9);
    exp_q.push_back({4'd1, 5'd10});
    repeat (3) begin
      btn(3, 1'b1);
      tick(1);
      btn(3, 1'b0);
      tick(1);
    end
    btn(3, 1'b1);
    tick(10);
    btn(3, 1'b0);
    tick(8);
    chk("bounce_pulses", pulses - p0, 1);
    chk("bounce_col", bus.frog_col, 10);

    // left edge
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back({4'd0, 5'(9 - i)});
      press(2);
    end
    chk("left_col0", bus.frog_col, 0);
    p0 = pulses;
`ifdef FROG_WRAP_EN
    exp_q.push_back({4'd0, 5'd19});
    press(2);
    chk("left_wrap_col", bus.frog_col, 19);
    chk("left_wrap_pulse", pulses - p0, 1);
`else
    press(2);
    chk("left_clamp_col", bus.frog_col, 0);
    chk("left_clamp_pulse", pulses - p0, 0);
`endif

    // collisions down to game over, then restart
    do_reset();
    bus.enemy_row = 4'd1;
    bus.enemy_col = 5'd9;
    hit_round(2'd2);
    hit_round(2'd1);
    hit_round(2'd0);
    chk("over_lives", bus.lives, 0);
    press(1);
    chk("over_restart", bus.game_over, 0);
    chk("over_restart_lives", bus.lives, 3);
    chk("over_restart_row", bus.frog_row, 0);

    // reach the top row and win, then restart
    bus.enemy_row = 4'd9;
    bus.enemy_col = 5'd19;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back({4'(i), 5'd9});
      press(0);
    end
    chk("win_row", bus.frog_row, 9);
    chk("win_flag", bus.won, 1);
    p0 = pulses;
    press(1);
    chk("win_restart", bus.won, 0);
    chk("win_restart_pos", {bus.frog_row, bus.frog_col}, {4'd0, 5'd9});
    chk("win_restart_lives", bus.lives, 3);
    chk("win_restart_pulse", pulses - p0, 0);

    // asynchronous reset in the middle of HIT
    bus.enemy_row = 4'd1;
    bus.enemy_col = 5'd9;
    exp_q.push_back({4'd1, 5'd9});
    btn(0, 1'b1);
    tick(10);
    chk("mid_hit", bus.hit, 1);
    #2 rev_reset = 1'b0;
    #1;
    chk("arst_hit", bus.hit, 0);
    chk("arst_lives", bus.lives, 3);
    chk("arst_pos", {bus.frog_row, bus.frog_col}, {4'd0, 5'd9});
    chk("arst_flags", {bus.won, bus.game_over, bus.move_pulse}, 0);
    btn(0, 1'b0);
    tick(2);
    rev_reset = 1'b1;
    p0 = pulses;
    tick(10);
    chk("post_rst_pulses", pulses - p0, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
